// File: rtl/jtag_tap_pkg.sv
// ---------------------------------------------------------------------------
// jtag_tap_pkg
// Shared definitions for the JTAG scan-register slice: instruction opcodes
// and the data-register select type decoded from the active instruction.
// Opcode constants are 5 bits wide, which is the default IR length. Wider
// instruction registers zero-extend them, except BYPASS, which is always
// all-ones.
// ---------------------------------------------------------------------------
package jtag_tap_pkg;

    localparam logic [4:0] INSTR_BYPASS = 5'h1F;
    localparam logic [4:0] INSTR_IDCODE = 5'h01;
    localparam logic [4:0] INSTR_USER   = 5'h11;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

endpackage

// File: rtl/jtag_scan_regs_if.sv
// ---------------------------------------------------------------------------
// jtag_scan_regs_if
// Groups the TAP-side serial path: the TAP controller strobes and TDI flow
// into the scan registers, and TDO/TDO-enable flow back out.
//   master : TAP controller side (drives strobes and tdi)
//   slave  : scan-register side (drives tdo, tdo_en)
// ---------------------------------------------------------------------------
interface jtag_scan_regs_if;
    logic tdi;
    logic tap_reset;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic tdo;
    logic tdo_en;

    modport master (
        output tdi, tap_reset, capture_ir, shift_ir, update_ir,
               capture_dr, shift_dr, update_dr,
        input  tdo, tdo_en
    );

    modport slave (
        input  tdi, tap_reset, capture_ir, shift_ir, update_ir,
               capture_dr, shift_dr, update_dr,
        output tdo, tdo_en
    );
endinterface

// File: rtl/jtag_ir_reg.sv
// ---------------------------------------------------------------------------
// jtag_ir_reg
// JTAG instruction register: a capture/shift buffer plus the active
// instruction latched on IR update.
// Ports:
//   clk, rst_n        TCK and asynchronous active-low reset
//   tdi_i             serial data in
//   tap_reset_i       TEST_LOGIC_RESET; reloads IDCODE, clears the buffer
//   capture_ir_i      load the fixed 0..01 capture pattern
//   shift_ir_i        shift tdi into the MSB, LSB leaves first
//   update_ir_i       copy the shift buffer into the active instruction
//   ir_lsb_o          current shift-buffer LSB (TDO source while shifting)
//   ir_value_o        active instruction
// Priority within a cycle: tap_reset > capture > shift > update.
// ---------------------------------------------------------------------------
module jtag_ir_reg
    import jtag_tap_pkg::*;
#(
    parameter int IR_LEN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tdi_i,
    input  logic              tap_reset_i,
    input  logic              capture_ir_i,
    input  logic              shift_ir_i,
    input  logic              update_ir_i,
    output logic              ir_lsb_o,
    output logic [IR_LEN-1:0] ir_value_o
);

    localparam logic [IR_LEN-1:0] IR_RESET   = IR_LEN'(INSTR_IDCODE);
    // Mandatory IR capture pattern: two LSBs are 01, remaining bits zero.
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_value_q, ir_value_d;

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_value_d = ir_value_q;
        if (tap_reset_i) begin
            ir_shift_d = '0;
            ir_value_d = IR_RESET;
        end else if (capture_ir_i) begin
            ir_shift_d = IR_CAPTURE;
        end else if (shift_ir_i) begin
            ir_shift_d = {tdi_i, ir_shift_q[IR_LEN-1:1]};
        end else if (update_ir_i) begin
            ir_value_d = ir_shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift_q <= '0;
            ir_value_q <= IR_RESET;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_value_q <= ir_value_d;
        end
    end

    assign ir_lsb_o   = ir_shift_q[0];
    assign ir_value_o = ir_value_q;

endmodule

// File: rtl/jtag_scan_regs.sv
// ---------------------------------------------------------------------------
// jtag_scan_regs
// Scan-register block downstream of the TAP state machine. Holds the IR
// (in jtag_ir_reg), the BYPASS bit, and a shared DR shift buffer used by
// both IDCODE and the user DR. Presents updated user-DR words as a
// single-cycle valid pulse.
// Ports:
//   clk, rst_n              TCK and asynchronous active-low reset
//   tap                     TAP strobes, tdi in, tdo/tdo_en out (slave)
//   ir_value_o              active instruction
//   user_capture_data_i     parallel value loaded on user-DR capture
//   user_update_data_o      last user-DR word written on DR update
//   user_update_valid_o     1-cycle pulse when user_update_data_o is written
// ---------------------------------------------------------------------------
module jtag_scan_regs
    import jtag_tap_pkg::*;
#(
    parameter int          IR_LEN      = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'h1DEAD3FF,
    parameter int          USER_DR_LEN = 41
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jtag_scan_regs_if.slave        tap,
    output logic [IR_LEN-1:0]      ir_value_o,
    input  logic [USER_DR_LEN-1:0] user_capture_data_i,
    output logic [USER_DR_LEN-1:0] user_update_data_o,
    output logic                   user_update_valid_o
);

    // IDCODE and the user DR share one buffer sized for the larger of the two.
    localparam int DR_W = (USER_DR_LEN > 32) ? USER_DR_LEN : 32;

    localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(INSTR_IDCODE);
    localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(INSTR_USER);

    logic                   ir_lsb;
    logic [IR_LEN-1:0]      ir_value;
    dr_sel_t                dr_sel;
    logic                   dr_lsb;

    logic [DR_W-1:0]        dr_shift_q, dr_shift_d;
    logic                   bypass_q, bypass_d;
    logic [USER_DR_LEN-1:0] user_upd_q, user_upd_d;
    logic                   user_vld_q, user_vld_d;
    logic                   tdo_q, tdo_d;

    jtag_ir_reg #(
        .IR_LEN (IR_LEN)
    ) u_ir (
        .clk          (clk),
        .rst_n        (rst_n),
        .tdi_i        (tap.tdi),
        .tap_reset_i  (tap.tap_reset),
        .capture_ir_i (tap.capture_ir),
        .shift_ir_i   (tap.shift_ir),
        .update_ir_i  (tap.update_ir),
        .ir_lsb_o     (ir_lsb),
        .ir_value_o   (ir_value)
    );

    // Undefined opcodes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value == IR_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_value == IR_USER) begin
            dr_sel = DR_USER;
        end
    end

    assign dr_lsb = (dr_sel == DR_BYPASS) ? bypass_q : dr_shift_q[0];

    // Each register shifts over its own width only: IDCODE enters tdi at
    // bit 31 even when the shared buffer is wider.
    always_comb begin
        dr_shift_d = dr_shift_q;
        bypass_d   = bypass_q;
        user_upd_d = user_upd_q;
        user_vld_d = 1'b0;
        if (tap.tap_reset) begin
            dr_shift_d = '0;
            bypass_d   = 1'b0;
        end else if (tap.capture_dr) begin
            case (dr_sel)
                DR_IDCODE: dr_shift_d[31:0]            = IDCODE_VAL;
                DR_USER:   dr_shift_d[USER_DR_LEN-1:0] = user_capture_data_i;
                default:   bypass_d                    = 1'b0;
            endcase
        end else if (tap.shift_dr) begin
            case (dr_sel)
                DR_IDCODE: begin
                    for (int i = 0; i < 31; i++) begin
                        dr_shift_d[i] = dr_shift_q[i+1];
                    end
                    dr_shift_d[31] = tap.tdi;
                end
                DR_USER: begin
                    for (int i = 0; i < USER_DR_LEN-1; i++) begin
                        dr_shift_d[i] = dr_shift_q[i+1];
                    end
                    dr_shift_d[USER_DR_LEN-1] = tap.tdi;
                end
                default: bypass_d = tap.tdi;
            endcase
        end else if (tap.update_dr && (dr_sel == DR_USER)) begin
            user_upd_d = dr_shift_q[USER_DR_LEN-1:0];
            user_vld_d = 1'b1;
        end
    end

    // TDO presents the LSB of the register being shifted in the same cycle,
    // so bit 0 is on the pin during the first shift cycle; between shifts it
    // holds its last driven value.
    always_comb begin
        tdo_d = tdo_q;
        if (tap.tap_reset) begin
            tdo_d = 1'b0;
        end else if (tap.shift_ir) begin
            tdo_d = ir_lsb;
        end else if (tap.shift_dr) begin
            tdo_d = dr_lsb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_shift_q <= '0;
            bypass_q   <= 1'b0;
            user_upd_q <= '0;
            user_vld_q <= 1'b0;
            tdo_q      <= 1'b0;
        end else begin
            dr_shift_q <= dr_shift_d;
            bypass_q   <= bypass_d;
            user_upd_q <= user_upd_d;
            user_vld_q <= user_vld_d;
            tdo_q      <= tdo_d;
        end
    end

    // Enable drops immediately on reset so the pin is released while rst_n
    // is low, even if the TAP is still signalling a shift state.
    assign tap.tdo             = tdo_d;
    assign tap.tdo_en          = rst_n & ~tap.tap_reset & (tap.shift_ir | tap.shift_dr);
    assign ir_value_o          = ir_value;
    assign user_update_data_o  = user_upd_q;
    assign user_update_valid_o = user_vld_q;

endmodule

// File: tb/tb_jtag_scan_regs.sv
// ---------------------------------------------------------------------------
// tb_jtag_scan_regs
// Scenario tasks drive the TAP strobes and compare the DUT against a
// queue-based model of a JTAG data/instruction register: capture loads a
// bit list, each shift pops the oldest bit to TDO and appends TDI.
// ---------------------------------------------------------------------------
module tb_jtag_scan_regs;

    localparam int          IR_LEN = 5;
    localparam logic [31:0] IDV    = 32'h1DEAD3FF;
    localparam int          UW     = 41;

    logic          clk;
    logic          rst_n;
    logic [4:0]    ir_value;
    logic [UW-1:0] ucap;
    logic [UW-1:0] upd_data;
    logic          upd_valid;

    int errors = 0;
    int checks = 0;

    logic [4:0]    m_ir;
    logic [UW-1:0] m_upd;

    jtag_scan_regs_if tap ();

    jtag_scan_regs #(
        .IR_LEN      (IR_LEN),
        .IDCODE_VAL  (IDV),
        .USER_DR_LEN (UW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tap                 (tap.slave),
        .ir_value_o          (ir_value),
        .user_capture_data_i (ucap),
        .user_update_data_o  (upd_data),
        .user_update_valid_o (upd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int sel_width(input logic [4:0] ir);
        if (ir == 5'h01) return 32;
        if (ir == 5'h11) return UW;
        return 1;
    endfunction

    function automatic logic [127:0] sel_capture(input logic [4:0] ir, input logic [UW-1:0] cap);
        if (ir == 5'h01) return 128'(IDV);
        if (ir == 5'h11) return 128'(cap);
        return 128'h0;
    endfunction

    function automatic void model_scan(input int w, input logic [127:0] cap, input int n,
                                       input logic [127:0] tv, output logic [127:0] exp_obs,
                                       output logic [127:0] exp_reg);
        bit q[$];
        exp_obs = '0;
        exp_reg = '0;
        for (int i = 0; i < w; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++) begin
            exp_obs[i] = q.pop_front();
            q.push_back(tv[i]);
        end
        for (int i = 0; i < w; i++) exp_reg[i] = q[i];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        tap.tdi = 1'b0;        tap.tap_reset = 1'b0;
        tap.capture_ir = 1'b0; tap.shift_ir = 1'b0; tap.update_ir = 1'b0;
        tap.capture_dr = 1'b0; tap.shift_dr = 1'b0; tap.update_dr = 1'b0;
    endtask

    task automatic ir_scan(input logic [4:0] val, output logic [127:0] obs, output int en_err);
        obs = '0;
        en_err = 0;
        tap.capture_ir = 1'b1; tick(); tap.capture_ir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tap.shift_ir = 1'b1;
            tap.tdi = val[i];
            @(negedge clk);
            obs[i] = tap.tdo;
            if (tap.tdo_en !== 1'b1) en_err++;
            tick();
        end
        tap.shift_ir = 1'b0; tap.tdi = 1'b0;
        tap.update_ir = 1'b1; tick(); tap.update_ir = 1'b0;
    endtask

    task automatic dr_scan(input int n, input logic [127:0] tv, input bit do_upd,
                           output logic [127:0] obs, output int pulses, output int en_err);
        obs = '0;
        pulses = 0;
        en_err = 0;
        tap.capture_dr = 1'b1;
        @(negedge clk); if (upd_valid) pulses++;
        tick(); tap.capture_dr = 1'b0;
        for (int i = 0; i < n; i++) begin
            tap.shift_dr = 1'b1;
            tap.tdi = tv[i];
            @(negedge clk);
            obs[i] = tap.tdo;
            if (tap.tdo_en !== 1'b1) en_err++;
            if (upd_valid) pulses++;
            tick();
        end
        tap.shift_dr = 1'b0; tap.tdi = 1'b0;
        if (do_upd) begin
            tap.update_dr = 1'b1;
            @(negedge clk); if (upd_valid) pulses++;
            tick(); tap.update_dr = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (upd_valid) pulses++;
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (ir_value !== 5'h01) begin errors++; $display("FAIL reset_ir: got %h expected 01", ir_value); end
        checks++; if (upd_data !== '0) begin errors++; $display("FAIL reset_upd: got %h expected 0", upd_data); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", upd_valid); end
        checks++; if (tap.tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tap.tdo); end
        checks++; if (tap.tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo_en: got %b expected 0", tap.tdo_en); end
        tick();
    endtask

    task automatic test_idcode();
        logic [127:0] obs, eo, er, tv;
        int pulses, en_err, n;
        // plain 32-bit readout, then a longer scan with random tdi
        for (int k = 0; k < 2; k++) begin
            n  = (k == 0) ? 32 : 40;
            tv = (k == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            model_scan(sel_width(m_ir), sel_capture(m_ir, ucap), n, tv, eo, er);
            dr_scan(n, tv, 1'b1, obs, pulses, en_err);
            checks++; if (obs !== eo) begin errors++; $display("FAIL idcode_tdo%0d: got %h expected %h", k, obs, eo); end
            checks++; if (pulses !== 0) begin errors++; $display("FAIL idcode_nopulse%0d: got %0d expected 0", k, pulses); end
            checks++; if (en_err !== 0) begin errors++; $display("FAIL idcode_tdo_en%0d: got %0d bad cycles expected 0", k, en_err); end
        end
        checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL idcode_ir: got %h expected %h", ir_value, m_ir); end
        checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL idcode_upd_hold: got %h expected %h", upd_data, m_upd); end
    endtask

    task automatic test_ir_load(input logic [4:0] code);
        logic [127:0] obs, eo, er;
        int en_err;
        model_scan(IR_LEN, 128'h1, IR_LEN, 128'(code), eo, er);
        ir_scan(code, obs, en_err);
        m_ir = er[4:0];
        checks++; if (obs !== eo) begin errors++; $display("FAIL ir_capture_tdo: got %h expected %h", obs, eo); end
        checks++; if (en_err !== 0) begin errors++; $display("FAIL ir_tdo_en: got %0d bad cycles expected 0", en_err); end
        checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL ir_value: got %h expected %h", ir_value, m_ir); end
    endtask

    task automatic test_user();
        logic [127:0] obs, eo, er, tv;
        int pulses, en_err, n;
        test_ir_load(5'h11);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                ucap = 41'h1_2345_6789A;
                tv   = 128'h0_AAAA_5555;
                n    = UW;
            end else begin
                ucap = UW'({$urandom, $urandom});
                tv   = {$urandom, $urandom, $urandom, $urandom};
                n    = $urandom_range(UW, UW + 9);
            end
            model_scan(sel_width(m_ir), sel_capture(m_ir, ucap), n, tv, eo, er);
            dr_scan(n, tv, 1'b1, obs, pulses, en_err);
            m_upd = er[UW-1:0];
            checks++; if (obs !== eo) begin errors++; $display("FAIL user_tdo%0d: got %h expected %h", k, obs, eo); end
            checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL user_upd%0d: got %h expected %h", k, upd_data, m_upd); end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL user_pulse%0d: got %0d expected 1", k, pulses); end
            checks++; if (en_err !== 0) begin errors++; $display("FAIL user_tdo_en%0d: got %0d expected 0", k, en_err); end
        end
    endtask

    task automatic test_bypass();
        logic [127:0] obs, eo, er;
        logic [4:0] codes [3];
        int pulses, en_err;
        codes[0] = 5'h1F;
        codes[1] = 5'h07;
        codes[2] = 5'($urandom);
        if (codes[2] == 5'h01 || codes[2] == 5'h11) codes[2] = 5'h1E;
        for (int k = 0; k < 3; k++) begin
            test_ir_load(codes[k]);
            model_scan(sel_width(m_ir), sel_capture(m_ir, ucap), 4, 128'hD, eo, er);
            dr_scan(4, 128'hD, 1'b1, obs, pulses, en_err);
            checks++; if (obs !== eo) begin errors++; $display("FAIL bypass_tdo%0d: got %h expected %h", k, obs, eo); end
            checks++; if (pulses !== 0) begin errors++; $display("FAIL bypass_nopulse%0d: got %0d expected 0", k, pulses); end
            checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL bypass_upd_hold%0d: got %h expected %h", k, upd_data, m_upd); end
        end
    endtask

    task automatic test_tap_reset();
        logic [127:0] obs;
        int pulses;
        test_ir_load(5'h11);
        ucap = UW'({$urandom, $urandom}) | 41'h1;
        tap.capture_dr = 1'b1; tick(); tap.capture_dr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tap.shift_dr = 1'b1; tap.tdi = 1'($urandom); tick();
        end
        // tap_reset wins over a simultaneous shift and update
        tap.tap_reset = 1'b1; tap.update_dr = 1'b1;
        @(negedge clk);
        checks++; if (tap.tdo_en !== 1'b0) begin errors++; $display("FAIL tapreset_tdo_en: got %b expected 0", tap.tdo_en); end
        tick();
        clear_strobes();
        m_ir = 5'h01;
        @(negedge clk);
        checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL tapreset_ir: got %h expected %h", ir_value, m_ir); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL tapreset_vld: got %b expected 0", upd_valid); end
        checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL tapreset_upd_hold: got %h expected %h", upd_data, m_upd); end
        checks++; if (tap.tdo !== 1'b0) begin errors++; $display("FAIL tapreset_tdo: got %b expected 0", tap.tdo); end
        tick();
        // buffer was cleared: shifting without capture reads all zeros
        obs = '0;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tap.shift_dr = 1'b1; tap.tdi = 1'b0;
            @(negedge clk);
            obs[i] = tap.tdo;
            if (upd_valid) pulses++;
            tick();
        end
        tap.shift_dr = 1'b0;
        checks++; if (obs !== 128'h0) begin errors++; $display("FAIL tapreset_dr_clear: got %h expected 0", obs); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL tapreset_nopulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_async_reset();
        test_ir_load(5'h11);
        ucap = '1;
        tap.capture_dr = 1'b1; tick(); tap.capture_dr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tap.shift_dr = 1'b1; tap.tdi = 1'b1; tick();
        end
        tap.update_dr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        m_ir  = 5'h01;
        m_upd = '0;
        checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL arst_ir: got %h expected %h", ir_value, m_ir); end
        checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL arst_upd: got %h expected 0", upd_data); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b expected 0", upd_valid); end
        checks++; if (tap.tdo !== 1'b0) begin errors++; $display("FAIL arst_tdo: got %b expected 0", tap.tdo); end
        checks++; if (tap.tdo_en !== 1'b0) begin errors++; $display("FAIL arst_tdo_en: got %b expected 0", tap.tdo_en); end
        #1 rst_n = 1'b1;
        clear_strobes();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (upd_valid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL arst_nopulse: got %b expected 0", upd_valid);
            end
            tick();
        end
        checks++; if (upd_data !== m_upd) begin errors++; $display("FAIL arst_upd_after: got %h expected 0", upd_data); end
        checks++; if (ir_value !== m_ir) begin errors++; $display("FAIL arst_ir_after: got %h expected %h", ir_value, m_ir); end
    endtask

    initial begin
        rst_n = 1'b0;
        ucap  = '0;
        m_ir  = 5'h01;
        m_upd = '0;
        clear_strobes();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_idcode();
        test_user();
        test_bypass();
        test_tap_reset();
        test_idcode();
        test_async_reset();
        test_idcode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
